hazard_forward_unit: RTL
========================

# hazard_forward_unit

Parametrised forwarding and load-use hazard unit for the 5-stage pipeline. It generalises operand forwarding to two producer stages (MEM and WB) with priority, write-enable gating and register-zero exclusion. It detects load-use hazards at decode and holds the front end for a configurable number of cycles via a small FSM. It also keeps saturating stall and forward event counters for performance debug.

## Interface
- ADDR_W, 3, register address width
- LOAD_LAT, 1, stall cycles per load-use hazard (≥1)
- ZERO_REG_EN, 1, when 1 register 0 is hardwired and never forwarded or stalled on
- CNT_W, 16, event counter width

One clock; reset is synchronous and active-high.

- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- id_rs_addr_i / id_rt_addr_i  in  ADDR_W  source registers of instruction in ID
- id_rs_used_i / id_rt_used_i  in  1  ID instruction actually reads rs / rt
- ex_rs_addr_i / ex_rt_addr_i  in  ADDR_W  source registers of instruction in EX
- ex_write_addr_i  in  ADDR_W  destination of instruction in EX
- ex_regwrite_i  in  1  EX instruction writes a register
- ex_memread_i  in  1  EX instruction is a load
- mem_write_addr_i  in  ADDR_W  destination in MEM
- mem_regwrite_i  in  1  MEM instruction writes a register
- mem_memread_i  in  1  MEM instruction is a load
- wb_write_addr_i  in  ADDR_W  destination in WB
- wb_regwrite_i  in  1  WB instruction writes a register
- cnt_clr_i  in  1  synchronous clear of both counters
- rs_muxcontrol_o / rt_muxcontrol_o  out  2  EX operand select: 0 regfile, 1 MEM result, 2 WB result
- stall_o  out  1  hold PC and IF/ID register
- flush_ex_o  out  1  insert bubble into ID/EX
- stall_cnt_o  out  CNT_W  stall cycles seen
- fwd_cnt_o  out  CNT_W  cycles with any forward active

## Operation
- Valid producer match on stage S: S_regwrite_i && S_write_addr_i == operand addr && !(ZERO_REG_EN && addr == 0).
- Forward select per operand, combinational: MEM match with mem_memread_i == 0 → 1; else WB match → 2; else 0. MEM has priority over WB. A MEM-stage load never drives select 1. It falls through to WB or 0.
- Hazard: ex_memread_i && ex_regwrite_i && ex_write_addr_i nonzero-or-!ZERO_REG_EN && ((id_rs_used_i && id_rs_addr_i == ex_write_addr_i) || (id_rt_used_i && id_rt_addr_i == ex_write_addr_i)).
- FSM states IDLE, STALL; counter rem (width clog2(LOAD_LAT+1)).
  - IDLE: stall_o = hazard. If hazard and LOAD_LAT > 1: rem <= LOAD_LAT-1, go to STALL. Otherwise stay in IDLE.
  - STALL: stall_o = 1 regardless of inputs. rem decrements each cycle; when rem == 1, go to IDLE next cycle.
- A hazard is never re-evaluated while in STALL. A new hazard in the first IDLE cycle after STALL starts a fresh stall.
- flush_ex_o == stall_o every cycle.
- Counters saturate at all-ones.
  - stall_cnt_o increments on each cycle with stall_o = 1.
  - fwd_cnt_o increments on each cycle with either select nonzero.
  - cnt_clr_i has priority over increment. Counter value is 0 in the cycle after clear.

## Timing
- Mux selects, stall_o and flush_ex_o are combinational from inputs and state. There is no added latency.
- Each hazard produces exactly LOAD_LAT consecutive stall_o cycles, counted from the detection cycle.
- Reset: state IDLE, rem 0, both counters 0. While rst_i = 1, stall_o, flush_ex_o and both selects are forced to 0.
- Reset mid-STALL aborts the stall. Stall cycles the aborted stall had not yet issued are dropped.
- Counters update on the clock edge. A counter reflects events up to the previous cycle.

## Structure
- Package hazard_pkg holds:
  - select constants FWD_RF = 2'd0, FWD_MEM = 2'd1, FWD_WB = 2'd2
  - state enum {ST_IDLE, ST_STALL}
- Sub-module sat_counter (parameter W; ports clk_i, rst_i, clr_i, inc_i, cnt_o) is used twice.
- Match logic is a function shared by the rs and rt paths.

## Test plan
- MEM dest 3 regwrite, WB dest 3 regwrite, ex_rs_addr 3 → rs select 1. Drop mem_regwrite → select 2. Drop both → 0.
- ZERO_REG_EN = 1, MEM dest 0 regwrite, ex_rt_addr 0 → rt select 0, no fwd_cnt increment.
- LOAD_LAT = 1: EX load dest 5, id_rs 5 used → stall_o/flush_ex_o high 1 cycle, then low. Same case with id_rs_used_i = 0 → no stall.
- LOAD_LAT = 3: hazard in cycle 0 → stall_o high cycles 0–2 even with EX inputs cleared, low in cycle 3. stall_cnt_o reads 3 in cycle 4.
- rst_i asserted in cycle 1 of a LOAD_LAT = 3 stall → stall_o 0 in cycle 1, IDLE in cycle 2, counters 0.
- CNT_W = 2, forward held 6 cycles → fwd_cnt_o saturates at 3. cnt_clr_i asserted concurrently with a forward → 0 in the next cycle.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: forward select encodings and stall FSM states for hazard_forward_unit
package hazard_pkg;
  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;
  typedef enum logic {ST_IDLE, ST_STALL} state_e;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating event counter with synchronous reset and clear
//   clk_i, rst_i: clock and sync active-high reset; clr_i: clear (beats inc_i);
//   inc_i: count this cycle; cnt_o: current count, sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) r_cnt <= '0;
    else if (inc_i && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end
  assign cnt_o = r_cnt;
endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: MEM/WB operand forwarding, load-use stall FSM and event counters
//   id_*: decode-stage sources; ex_*/mem_*/wb_*: producer stages; cnt_clr_i: clear counters
//   rs/rt_muxcontrol_o: EX operand select; stall_o/flush_ex_o: front-end hold + bubble
//   stall_cnt_o/fwd_cnt_o: saturating stall-cycle and forward-cycle counts
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int ADDR_W      = 3,
  parameter int LOAD_LAT    = 1,
  parameter int ZERO_REG_EN = 1,
  parameter int CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] id_rs_addr_i,
  input  logic [ADDR_W-1:0] id_rt_addr_i,
  input  logic              id_rs_used_i,
  input  logic              id_rt_used_i,
  input  logic [ADDR_W-1:0] ex_rs_addr_i,
  input  logic [ADDR_W-1:0] ex_rt_addr_i,
  input  logic [ADDR_W-1:0] ex_write_addr_i,
  input  logic              ex_regwrite_i,
  input  logic              ex_memread_i,
  input  logic [ADDR_W-1:0] mem_write_addr_i,
  input  logic              mem_regwrite_i,
  input  logic              mem_memread_i,
  input  logic [ADDR_W-1:0] wb_write_addr_i,
  input  logic              wb_regwrite_i,
  input  logic              cnt_clr_i,
  output logic [1:0]        rs_muxcontrol_o,
  output logic [1:0]        rt_muxcontrol_o,
  output logic              stall_o,
  output logic              flush_ex_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  fwd_cnt_o
);
  localparam int REM_W = $clog2(LOAD_LAT + 1);
  function automatic logic f_match(input logic we, input logic [ADDR_W-1:0] wa, input logic [ADDR_W-1:0] a);
    return we && wa == a && !(ZERO_REG_EN != 0 && a == '0);
  endfunction
  state_e           r_state, w_state_next;
  logic [REM_W-1:0] r_rem, w_rem_next;
  logic             w_hazard, w_stall;
  logic [1:0]       w_rs_sel, w_rt_sel;
  always_comb begin
    // a MEM-stage load has no result yet, so it falls through to WB or regfile
    w_rs_sel = rst_i ? FWD_RF
             : (f_match(mem_regwrite_i, mem_write_addr_i, ex_rs_addr_i) && !mem_memread_i) ? FWD_MEM
             : f_match(wb_regwrite_i, wb_write_addr_i, ex_rs_addr_i) ? FWD_WB : FWD_RF;
    w_rt_sel = rst_i ? FWD_RF
             : (f_match(mem_regwrite_i, mem_write_addr_i, ex_rt_addr_i) && !mem_memread_i) ? FWD_MEM
             : f_match(wb_regwrite_i, wb_write_addr_i, ex_rt_addr_i) ? FWD_WB : FWD_RF;
    // matching on the ID source is equivalent to matching the EX dest, zero-reg rule included
    w_hazard = ex_memread_i
             && ((id_rs_used_i && f_match(ex_regwrite_i, ex_write_addr_i, id_rs_addr_i))
             ||  (id_rt_used_i && f_match(ex_regwrite_i, ex_write_addr_i, id_rt_addr_i)));
    w_state_next = r_state;
    w_rem_next   = r_rem;
    if (r_state == ST_IDLE) begin
      if (w_hazard && LOAD_LAT > 1) begin
        w_state_next = ST_STALL;
        w_rem_next   = REM_W'(LOAD_LAT - 1);
      end
    end else begin
      w_rem_next = r_rem - 1'b1;
      if (r_rem == REM_W'(1)) w_state_next = ST_IDLE;
    end
    w_stall = !rst_i && (r_state == ST_STALL || w_hazard);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_next;
      r_rem   <= w_rem_next;
    end
  end
  assign rs_muxcontrol_o = w_rs_sel;
  assign rt_muxcontrol_o = w_rt_sel;
  assign stall_o         = w_stall;
  assign flush_ex_o      = w_stall;
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(cnt_clr_i), .inc_i(w_stall), .cnt_o(stall_cnt_o)
  );
  sat_counter #(.W(CNT_W)) u_fwd_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(cnt_clr_i), .inc_i(w_rs_sel != FWD_RF || w_rt_sel != FWD_RF),
    .cnt_o(fwd_cnt_o)
  );
endmodule
